// File: rtl/clint_cmp_sched_pkg.sv
// Shared constants and helpers for the CLINT compare scheduler.
package clint_cmp_sched_pkg;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int unsigned CLINT_TIME_WIDTH   = 64;
  localparam int unsigned CLINT_DATA_WIDTH   = 32;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_e;

  // Hart index width; a single hart still gets a 1-bit index.
  function automatic int unsigned hart_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clint_rr_ptr.sv
// Wrapping round-robin scan pointer with an optional load (priority jump) port.
module clint_rr_ptr #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_en_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] ptr_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] ptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else if (N == 1) begin
      ptr_q <= '0;
    end else if (load_en_i) begin
      ptr_q <= load_val_i;
    end else if (ptr_q == LAST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_q + W'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/clint_cmp_sched.sv
// Per-hart mtimecmp storage with one shared 64-bit comparator scanned round-robin.
// Define CLINT_SCHED_PRIO_EN to make the scan jump to a hart right after it is written.
module clint_cmp_sched
  import clint_cmp_sched_pkg::*;
#(
  parameter int unsigned HART_NUM = 4,
  parameter int unsigned HART_W   = hart_w(HART_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [63:0]           mtime_i,
  input  logic                  cmp_wr_en_i,
  input  logic [HART_W-1:0]     cmp_wr_hart_i,
  input  logic                  cmp_wr_hi_i,
  input  logic [31:0]           cmp_wr_dat_i,
  input  logic [HART_W-1:0]     cmp_rd_hart_i,
  input  logic                  cmp_rd_hi_i,
  output logic [31:0]           cmp_rd_dat_o,
  output logic [HART_NUM-1:0]   mtip_o,
  output logic [HART_W-1:0]     scan_ptr_o
);

  logic [63:0]         cmp_q [HART_NUM];
  logic                wr_acc;
  logic [HART_W-1:0]   ptr;
  logic                ptr_ld;
  logic [63:0]         s0_cmp;
  logic                s0_kill;
  logic                s1_vld;
  logic [HART_W-1:0]   s1_hart;
  logic [63:0]         s1_cmp;
  logic                s1_kill;
  logic                hit;
  logic [63:0]         rd_cmp;
  logic [HART_NUM-1:0] mtip_q;

  assign wr_acc  = cmp_wr_en_i && (32'(cmp_wr_hart_i) < HART_NUM);
  assign s0_kill = wr_acc && (cmp_wr_hart_i == ptr);
  assign s1_kill = wr_acc && (cmp_wr_hart_i == s1_hart);
  assign hit     = (mtime_i >= s1_cmp);

`ifdef CLINT_SCHED_PRIO_EN
  assign ptr_ld = wr_acc;
`else
  assign ptr_ld = 1'b0;
`endif

  clint_rr_ptr #(
    .N(HART_NUM),
    .W(HART_W)
  ) u_rr_ptr (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_en_i  (ptr_ld),
    .load_val_i (cmp_wr_hart_i),
    .ptr_o      (ptr)
  );

  // Muxes are written as loops so non-power-of-two HART_NUM never indexes past the array.
  always_comb begin
    s0_cmp = CLINT_MTIMECMP_RST;
    rd_cmp = CLINT_MTIMECMP_RST;
    for (int unsigned i = 0; i < HART_NUM; i++) begin
      if (32'(ptr) == i)           s0_cmp = cmp_q[i];
      if (32'(cmp_rd_hart_i) == i) rd_cmp = cmp_q[i];
    end
  end

  assign cmp_rd_dat_o = (half_e'(cmp_rd_hi_i) == HALF_HI) ? rd_cmp[63:32] : rd_cmp[31:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < HART_NUM; i++) cmp_q[i] <= CLINT_MTIMECMP_RST;
    end else begin
      for (int unsigned i = 0; i < HART_NUM; i++) begin
        if (wr_acc && (32'(cmp_wr_hart_i) == i)) begin
          if (half_e'(cmp_wr_hi_i) == HALF_HI) cmp_q[i][63:32] <= cmp_wr_dat_i;
          else                                 cmp_q[i][31:0]  <= cmp_wr_dat_i;
        end
      end
    end
  end

  // A write squashes the hart's in-flight entry and clears its pending level on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld  <= 1'b0;
      s1_hart <= '0;
      s1_cmp  <= CLINT_MTIMECMP_RST;
      mtip_q  <= '0;
    end else begin
      s1_vld  <= !s0_kill;
      s1_hart <= ptr;
      s1_cmp  <= s0_cmp;
      for (int unsigned i = 0; i < HART_NUM; i++) begin
        if (s1_vld && !s1_kill && (32'(s1_hart) == i)) mtip_q[i] <= hit;
        if (wr_acc && (32'(cmp_wr_hart_i) == i))       mtip_q[i] <= 1'b0;
      end
    end
  end

  assign mtip_o     = mtip_q;
  assign scan_ptr_o = ptr;

endmodule

// File: tb/tb_clint_cmp_sched.sv
// Scoreboard bench for clint_cmp_sched: stimulus queues expectations, a negedge monitor checks them.
module tb_clint_cmp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mtime;
  logic        wr_en, wr_en3;
  logic [1:0]  wr_hart;
  logic        wr_hi;
  logic [31:0] wr_dat;
  logic [1:0]  rd_hart;
  logic        rd_hi;
  logic [31:0] rd_dat, rd_dat3;
  logic [3:0]  mtip;
  logic [2:0]  mtip3;
  logic [1:0]  ptr, ptr3;

  always #5 clk = ~clk;

  clint_cmp_sched #(.HART_NUM(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mtime_i(mtime),
    .cmp_wr_en_i(wr_en), .cmp_wr_hart_i(wr_hart), .cmp_wr_hi_i(wr_hi), .cmp_wr_dat_i(wr_dat),
    .cmp_rd_hart_i(rd_hart), .cmp_rd_hi_i(rd_hi), .cmp_rd_dat_o(rd_dat),
    .mtip_o(mtip), .scan_ptr_o(ptr)
  );

  clint_cmp_sched #(.HART_NUM(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .mtime_i(mtime),
    .cmp_wr_en_i(wr_en3), .cmp_wr_hart_i(wr_hart), .cmp_wr_hi_i(wr_hi), .cmp_wr_dat_i(wr_dat),
    .cmp_rd_hart_i(rd_hart), .cmp_rd_hi_i(rd_hi), .cmp_rd_dat_o(rd_dat3),
    .mtip_o(mtip3), .scan_ptr_o(ptr3)
  );

  typedef enum int {K_MTIP, K_RD, K_PTR, K_MTIP3, K_RD3, K_PTR3} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [63:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_v(input string name, input kind_e k, input logic [63:0] e);
    chk_t c;
    c.name = name;
    c.kind = k;
    c.exp  = e;
    sb.push_back(c);
  endtask

  chk_t        mc;
  logic [63:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mc = sb.pop_front();
      case (mc.kind)
        K_MTIP:  act = 64'(mtip);
        K_RD:    act = 64'(rd_dat);
        K_PTR:   act = 64'(ptr);
        K_MTIP3: act = 64'(mtip3);
        K_RD3:   act = 64'(rd_dat3);
        K_PTR3:  act = 64'(ptr3);
        default: act = '0;
      endcase
      checks++;
      if (act !== mc.exp) begin
        failures++;
        $display("FAIL %s: actual=0x%0h required=0x%0h", mc.name, act, mc.exp);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] h, input logic hi, input logic [31:0] d, input logic to3 = 1'b0);
    wr_hart = h;
    wr_hi   = hi;
    wr_dat  = d;
    if (to3) wr_en3 = 1'b1;
    else     wr_en  = 1'b1;
    cyc();
    wr_en  = 1'b0;
    wr_en3 = 1'b0;
  endtask

  task automatic poll_bit(input int b, input int lim);
    for (int i = 0; i < lim && !mtip[b]; i++) cyc();
  endtask

  task automatic wait_ptr(input logic [1:0] p);
    for (int i = 0; i < 8 && ptr !== p; i++) cyc();
    expect_v("wait_ptr", K_PTR, 64'(p));
  endtask

  logic [63:0] st_mtime [5] = '{64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h2FFF};
  logic [3:0]  st_exp   [5] = '{4'b0100, 4'b1100, 4'b1110, 4'b1111, 4'b1100};

  initial begin
    rst_n = 1'b0; mtime = '0; wr_en = 1'b0; wr_en3 = 1'b0;
    wr_hart = '0; wr_hi = 1'b0; wr_dat = '0; rd_hart = '0; rd_hi = 1'b0;
    #2;
    expect_v("rst_mtip", K_MTIP, 64'h0);
    expect_v("rst_ptr",  K_PTR,  64'h0);
    for (int h = 0; h < 4; h++) begin
      for (int s = 0; s < 2; s++) begin
        rd_hart = h[1:0];
        rd_hi   = s[0];
        expect_v("rst_rd", K_RD, 64'hFFFF_FFFF);
        if (h < 3) expect_v("rst_rd3", K_RD3, 64'hFFFF_FFFF);
        cyc();
      end
    end
    cyc(32);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_v("ptr_seq",  K_PTR,  64'(i % 4));
      expect_v("ptr3_seq", K_PTR3, 64'(i % 3));
      cyc();
    end

    // threshold crossing on hart 2
    mtime = 64'hFF;
    wr(2'd2, 1'b1, 32'h0);
    wr(2'd2, 1'b0, 32'h100);
    cyc(6);
    expect_v("below_thresh", K_MTIP, 64'h0);
    mtime = 64'h100;
    poll_bit(2, 5);
    expect_v("cross", K_MTIP, 64'b0100);

    // clear by write on hart 1
    mtime = 64'h200;
    wr(2'd1, 1'b1, 32'h0);
    wr(2'd1, 1'b0, 32'h100);
    poll_bit(1, 6);
    expect_v("hart1_set", K_MTIP, 64'b0110);
    wr(2'd1, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      expect_v("clr_by_write", K_MTIP, 64'b0100);
      cyc();
    end
    rd_hart = 2'd1; rd_hi = 1'b1;
    expect_v("rd_h1_hi", K_RD, 64'hFFFF_FFFF);
    cyc();
    rd_hi = 1'b0;
    expect_v("rd_h1_lo", K_RD, 64'h100);
    cyc();
    rd_hart = 2'd2; rd_hi = 1'b1;
    expect_v("rd_h2_hi", K_RD, 64'h0);
    cyc();

    // hazard: hart 3 written while in S0
    wr(2'd3, 1'b1, 32'h0);
    wr(2'd3, 1'b0, 32'h0);
    poll_bit(3, 6);
    expect_v("hz_arm", K_MTIP, 64'b1100);
    wait_ptr(2'd3);
    wr(2'd3, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      expect_v("hz_s0", K_MTIP, 64'b0100);
      cyc();
    end
    // hazard: hart 3 written while in S1
    wr(2'd3, 1'b1, 32'h0);
    poll_bit(3, 6);
    expect_v("hz_rearm", K_MTIP, 64'b1100);
    wait_ptr(2'd0);
    wr(2'd3, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      expect_v("hz_s1", K_MTIP, 64'b0100);
      cyc();
    end

    // 64-bit boundary on hart 0
    wr(2'd0, 1'b1, 32'h1);
    wr(2'd0, 1'b0, 32'h0);
    mtime = 64'h0000_0000_FFFF_FFFF;
    cyc(6);
    expect_v("b64_below", K_MTIP, 64'b0100);
    mtime = 64'h0000_0001_0000_0000;
    cyc(6);
    expect_v("b64_at", K_MTIP, 64'b0101);

    // pointer behaviour after a write to hart 0 with the pointer at 1
    wait_ptr(2'd1);
    wr(2'd0, 1'b0, 32'h0);
`ifdef CLINT_SCHED_PRIO_EN
    expect_v("ptr_jump", K_PTR, 64'd0);
`else
    expect_v("ptr_jump", K_PTR, 64'd2);
`endif

    // staggered thresholds, low half first to avoid transient hits
    mtime = '0;
    wr(2'd0, 1'b0, 32'h4000); wr(2'd0, 1'b1, 32'h0);
    wr(2'd1, 1'b0, 32'h3000); wr(2'd1, 1'b1, 32'h0);
    wr(2'd2, 1'b0, 32'h1000); wr(2'd2, 1'b1, 32'h0);
    wr(2'd3, 1'b0, 32'h2000); wr(2'd3, 1'b1, 32'h0);
    cyc(6);
    expect_v("stag_idle", K_MTIP, 64'b0000);
    for (int i = 0; i < 5; i++) begin
      mtime = st_mtime[i];
      cyc(6);
      expect_v("stag", K_MTIP, 64'(st_exp[i]));
    end

    // HART_NUM = 3: index 3 is out of range
    expect_v("d3_idle", K_MTIP3, 64'h0);
    wr(2'd3, 1'b0, 32'h0, 1'b1);
    wr(2'd3, 1'b1, 32'h0, 1'b1);
    cyc(6);
    expect_v("d3_oor", K_MTIP3, 64'h0);
    rd_hi = 1'b0;
    for (int h = 0; h < 3; h++) begin
      rd_hart = h[1:0];
      expect_v("d3_oor_rd", K_RD3, 64'hFFFF_FFFF);
      cyc();
    end
    wr(2'd2, 1'b0, 32'h0, 1'b1);
    wr(2'd2, 1'b1, 32'h0, 1'b1);
    cyc(6);
    expect_v("d3_ctl", K_MTIP3, 64'b100);

    // asynchronous reset mid-scan
    cyc(2);
    rst_n   = 1'b0;
    rd_hart = 2'd2;
    rd_hi   = 1'b0;
    expect_v("arst_mtip",  K_MTIP,  64'h0);
    expect_v("arst_ptr",   K_PTR,   64'h0);
    expect_v("arst_rd",    K_RD,    64'hFFFF_FFFF);
    expect_v("arst_mtip3", K_MTIP3, 64'h0);
    @(negedge clk);
    #1;
    checks++;
    if (mtip !== 4'b0000) begin
      failures++;
      $display("FAIL arst_mtip_direct: actual=0x%0h required=0x0", mtip);
    end
    checks++;
    if (ptr !== 2'd0) begin
      failures++;
      $display("FAIL arst_ptr_direct: actual=0x%0h required=0x0", ptr);
    end
    checks++;
    if (rd_dat !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL arst_rd_direct: actual=0x%0h required=0xffffffff", rd_dat);
    end
    checks++;
    if (mtip3 !== 3'b000) begin
      failures++;
      $display("FAIL arst_mtip3_direct: actual=0x%0h required=0x0", mtip3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
